q_max_finder: RTL and testbench

Reads every action entry of one state's row from the Q-table and returns the largest Q-value together with its action index. It is the read-side companion to the Q-value updater, which writes Q-table entries. It produces the max_Q operand the updater consumes: the best Q-value of the next state. The block is a small FSM driving a synchronous-read Q-table port, with a start/busy/done handshake toward the learning controller.

---
 rtl/q_max_finder.sv | 103 ++++++++++
 tb/tb_q_max_finder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_max_finder.sv
// Scans one Q-table row through a synchronous-read port and reports the
// signed maximum Q-value together with its action index.
module q_max_finder #(
  parameter int N_ACTIONS = 4,
  parameter int ACT_W     = 2,
  parameter int STATE_W   = 4,
  parameter int Q_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [STATE_W-1:0]       state,
  output logic                     rd_en,
  output logic [STATE_W+ACT_W-1:0] rd_addr,
  input  logic [Q_W-1:0]           rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [Q_W-1:0]           max_Q,
  output logic [ACT_W-1:0]         best_action
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } fsm_t;

  localparam logic [ACT_W-1:0] LAST = ACT_W'(N_ACTIONS - 1);

  fsm_t               fsm;
  fsm_t               fsm_nx;
  logic [ACT_W-1:0]   cnt;
  logic [STATE_W-1:0] lat;
  logic               vld;
  logic [ACT_W-1:0]   tag;
  logic [Q_W-1:0]     run_max;
  logic [ACT_W-1:0]   run_idx;
  logic [Q_W-1:0]     nxt_max;
  logic [ACT_W-1:0]   nxt_idx;

  always_comb begin
    fsm_nx = fsm;
    unique case (fsm)
      S_IDLE:  if (start) fsm_nx = S_ISSUE;
      S_ISSUE: if (cnt == LAST) fsm_nx = S_DRAIN;
      S_DRAIN: fsm_nx = S_DONE;
      S_DONE:  fsm_nx = S_IDLE;
      default: fsm_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (fsm == S_ISSUE);
    rd_addr = rd_en ? {lat, cnt} : '0;
    busy    = (fsm != S_IDLE);
    done    = (fsm == S_DONE);
  end

  // Tag 0 marks the first datum; strict > keeps the lower index on ties.
  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    if (vld) begin
      if (tag == '0 || $signed(rd_data) > $signed(run_max)) begin
        nxt_max = rd_data;
        nxt_idx = tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= S_IDLE;
      cnt         <= '0;
      lat         <= '0;
      vld         <= 1'b0;
      tag         <= '0;
      run_max     <= '0;
      run_idx     <= '0;
      max_Q       <= '0;
      best_action <= '0;
    end else begin
      fsm     <= fsm_nx;
      vld     <= rd_en;
      tag     <= cnt;
      run_max <= nxt_max;
      run_idx <= nxt_idx;
      if (fsm == S_IDLE && start) begin
        lat <= state;
        cnt <= '0;
      end else if (fsm == S_ISSUE) begin
        cnt <= cnt + ACT_W'(1);
      end
      // Last datum lands in DRAIN, so publish the combined result.
      if (fsm == S_DRAIN) begin
        max_Q       <= nxt_max;
        best_action <= nxt_idx;
      end
    end
  end

endmodule

// File: tb/tb_q_max_finder.sv
// Scoreboard bench for q_max_finder: a synchronous-read table model feeds
// the DUT and each scan's expected max/index is queued at start.
module tb_q_max_finder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  state;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] max_Q;
  logic [1:0]  best_action;

  q_max_finder dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .state(state),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .max_Q(max_Q),
    .best_action(best_action)
  );

  typedef struct {
    logic [15:0] q;
    logic [1:0]  a;
  } exp_t;

  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;
  bit   rd_seen;
  exp_t sb[$];
  logic [5:0]  addr_log[$];
  logic [15:0] mem [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(negedge clk) begin
    if (rd_en) begin
      rd_seen = 1'b1;
      addr_log.push_back(rd_addr);
    end
    if (done) done_cnt++;
  end

  function automatic exp_t model(input logic [3:0] st);
    exp_t e;
    logic [15:0] v;
    e.q = mem[{st, 2'd0}];
    e.a = 2'd0;
    for (int a = 1; a < 4; a++) begin
      v = mem[{st, 2'(a)}];
      if ($signed(v) > $signed(e.q)) begin
        e.q = v;
        e.a = 2'(a);
      end
    end
    return e;
  endfunction

  task automatic load_row(input logic [3:0] st, input logic [15:0] r0,
                          input logic [15:0] r1, input logic [15:0] r2,
                          input logic [15:0] r3);
    mem[{st, 2'd0}] = r0;
    mem[{st, 2'd1}] = r1;
    mem[{st, 2'd2}] = r2;
    mem[{st, 2'd3}] = r3;
  endtask

  task automatic kick(input logic [3:0] st, output int t0);
    @(negedge clk);
    start = 1'b1;
    state = st;
    t0 = cyc;
    sb.push_back(model(st));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    state = 4'd0;
    rd_seen = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rd_en, rd_addr, busy, done} !== 9'd0) begin
      bad++;
      $display("FAIL reset_ctl got=%h want=0", {rd_en, rd_addr, busy, done});
    end
    total++;
    if (max_Q !== 16'd0 || best_action !== 2'd0) begin
      bad++;
      $display("FAIL reset_out got=%h/%0d want=0/0", max_Q, best_action);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (rd_seen !== 1'b0) begin
      bad++;
      $display("FAIL idle_rd_en got=%0b want=0", rd_seen);
    end
  endtask

  task automatic scan_check(input string nm, input logic [3:0] st,
                            input logic [15:0] wq, input logic [1:0] wa);
    int   t0;
    int   at;
    bit   ok;
    exp_t e;
    addr_log.delete();
    kick(st, t0);
    wait_done(ok, at);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout got=no_done want=done", nm);
      return;
    end
    e = sb.pop_front();
    total++;
    if (at - t0 !== 6) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=6", nm, at - t0);
    end
    total++;
    if (max_Q !== e.q || max_Q !== wq) begin
      bad++;
      $display("FAIL %s_max got=%h want=%h", nm, max_Q, wq);
    end
    total++;
    if (best_action !== e.a || best_action !== wa) begin
      bad++;
      $display("FAIL %s_idx got=%0d want=%0d", nm, best_action, wa);
    end
    total++;
    if (addr_log.size() !== 4) begin
      bad++;
      $display("FAIL %s_nreads got=%0d want=4", nm, addr_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (addr_log[k] !== {st, 2'(k)}) begin
          bad++;
          $display("FAIL %s_addr%0d got=%h want=%h", nm, k, addr_log[k],
                   {st, 2'(k)});
        end
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || max_Q !== wq) begin
      bad++;
      $display("FAIL %s_post got=%0b%0b/%h want=00/%h", nm, done, busy,
               max_Q, wq);
    end
  endtask

  task automatic test_basic;
    load_row(4'd3, 16'h0100, 16'h0280, 16'hFF00, 16'h0080);
    scan_check("basic", 4'd3, 16'h0280, 2'd1);
  endtask

  task automatic test_neg_tie;
    load_row(4'd5, 16'hFE00, 16'hFF80, 16'hFF80, 16'h8000);
    scan_check("negtie", 4'd5, 16'hFF80, 2'd1);
  endtask

  task automatic test_start_busy;
    int t0;
    int at;
    int d0;
    bit ok;
    exp_t e;
    load_row(4'd2, 16'h0010, 16'h0020, 16'h0300, 16'h0300);
    load_row(4'd9, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    addr_log.delete();
    d0 = done_cnt;
    kick(4'd2, t0);
    @(negedge clk);
    start = 1'b1;
    state = 4'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, at);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL busy_timeout got=no_done want=done");
      return;
    end
    e = sb.pop_front();
    total++;
    if (max_Q !== e.q || best_action !== e.a) begin
      bad++;
      $display("FAIL busy_result got=%h/%0d want=%h/%0d", max_Q, best_action,
               e.q, e.a);
    end
    repeat (12) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL busy_ndone got=%0d want=1", done_cnt - d0);
    end
    total++;
    if (addr_log.size() !== 4 || addr_log[0][5:2] !== 4'd2 ||
        addr_log[3][5:2] !== 4'd2) begin
      bad++;
      $display("FAIL busy_prefix got=%0d reads want=4 at state 2",
               addr_log.size());
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    int d0;
    load_row(4'd7, 16'h0400, 16'h0500, 16'h0600, 16'h0700);
    d0 = done_cnt;
    kick(4'd7, t0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (rd_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ctl got=%0b%0b want=00", rd_en, busy);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 0) begin
      bad++;
      $display("FAIL rstmid_done got=%0d want=0", done_cnt - d0);
    end
    total++;
    if (max_Q !== 16'd0 || best_action !== 2'd0) begin
      bad++;
      $display("FAIL rstmid_out got=%h/%0d want=0/0", max_Q, best_action);
    end
    load_row(4'd0, 16'h0700, 16'h0000, 16'h0000, 16'h0000);
    scan_check("after_rst", 4'd0, 16'h0700, 2'd0);
  endtask

  task automatic test_back_to_back;
    int   t1;
    int   t2;
    bit   ok;
    exp_t e;
    load_row(4'd4, 16'h8000, 16'h8001, 16'h8000, 16'h8000);
    load_row(4'd6, 16'h0005, 16'h0001, 16'h0002, 16'h0050);
    @(negedge clk);
    start = 1'b1;
    state = 4'd4;
    sb.push_back(model(4'd4));
    @(negedge clk);
    state = 4'd6;
    sb.push_back(model(4'd6));
    wait_done(ok, t1);
    total++;
    if (!ok) begin
      bad++;
      start = 1'b0;
      $display("FAIL b2b_timeout1 got=no_done want=done");
      return;
    end
    e = sb.pop_front();
    total++;
    if (max_Q !== e.q || best_action !== e.a || max_Q !== 16'h8001) begin
      bad++;
      $display("FAIL b2b_first got=%h/%0d want=%h/%0d", max_Q, best_action,
               e.q, e.a);
    end
    wait_done(ok, t2);
    start = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_timeout2 got=no_done want=done");
      return;
    end
    e = sb.pop_front();
    total++;
    if (max_Q !== e.q || best_action !== e.a || best_action !== 2'd3) begin
      bad++;
      $display("FAIL b2b_second got=%h/%0d want=%h/%0d", max_Q, best_action,
               e.q, e.a);
    end
    total++;
    if (t2 - t1 !== 7) begin
      bad++;
      $display("FAIL b2b_spacing got=%0d want=7", t2 - t1);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || sb.size() !== 0) begin
      bad++;
      $display("FAIL b2b_idle got=%0b/%0d want=0/0", busy, sb.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    done_cnt = 0;
    rd_seen = 1'b0;
    rd_data = 16'd0;
    rst = 1'b1;
    start = 1'b0;
    state = 4'd0;
    for (int i = 0; i < 64; i++) mem[i] = 16'd0;
    test_reset;
    test_basic;
    test_neg_tie;
    test_start_busy;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
